irq_trap_ctrl: RTL and testbench

Sequencing controller for machine-mode interrupt entry, `mret` exit and WFI sleep. It sits between the interrupt request/cause logic and the commit stage, PC unit and CSR file. It chooses the commit boundary at which an interrupt is taken and latches the return PC and cause. It then drives a pipeline flush handshake to the trap vector and pulses the CSR update strobes. It also owns the WFI sleep flag that feeds back into interrupt qualification.

---
 rtl/irq_trap_ctrl_if.sv | 46 ++++
 rtl/irq_trap_ctrl.sv | 139 +++++++++++++
 tb/tb_irq_trap_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_trap_ctrl_if.sv
// Bus between irq_trap_ctrl and its neighbours: interrupt request/cause,
// commit-stage info, CSR views, the flush handshake and the CSR/mstatus strobes.
interface irq_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            dbg_mode;
  logic            irq_req;
  logic            wfi_irq_req;
  logic [XLEN-1:0] irq_cause;
  logic            cmt_vld;
  logic [XLEN-1:0] cmt_pc;
  logic            cmt_is_wfi;
  logic            cmt_is_mret;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic            cmt_kill;
  logic            flush_req;
  logic [XLEN-1:0] flush_pc;
  logic            flush_ack;
  logic            mepc_we;
  logic            mcause_we;
  logic [XLEN-1:0] mepc_wdata;
  logic [XLEN-1:0] mcause_wdata;
  logic            trap_enter;
  logic            trap_exit;
  logic            wfi_flag_r;
  logic            halt_req;

  modport slave (
    input  dbg_mode, irq_req, wfi_irq_req, irq_cause,
    input  cmt_vld, cmt_pc, cmt_is_wfi, cmt_is_mret,
    input  csr_mtvec, csr_mepc, flush_ack,
    output cmt_kill, flush_req, flush_pc,
    output mepc_we, mcause_we, mepc_wdata, mcause_wdata,
    output trap_enter, trap_exit, wfi_flag_r, halt_req
  );

  modport master (
    output dbg_mode, irq_req, wfi_irq_req, irq_cause,
    output cmt_vld, cmt_pc, cmt_is_wfi, cmt_is_mret,
    output csr_mtvec, csr_mepc, flush_ack,
    input  cmt_kill, flush_req, flush_pc,
    input  mepc_we, mcause_we, mepc_wdata, mcause_wdata,
    input  trap_enter, trap_exit, wfi_flag_r, halt_req
  );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt entry / mret exit / WFI sleep sequencer.
// Define IRQ_VECTORED_EN to enable vectored mtvec mode for interrupts.
module irq_trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  irq_trap_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAP,
    ST_RET,
    ST_SLEEP,
    ST_WAKE
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_ret_pc;
  logic [XLEN-1:0] w_ret_pc_nxt;
  logic [XLEN-1:0] r_cause_q;
  logic [XLEN-1:0] w_cause_nxt;
  logic [XLEN-1:0] r_flush_pc;
  logic [XLEN-1:0] w_flush_pc_nxt;
  logic            r_flush_req;
  logic            r_wfi_flag;
  logic            w_kill;
  logic            w_trap_done;
  logic            w_ret_done;
  logic [XLEN-1:0] w_mtvec_base;
  logic [XLEN-1:0] w_trap_target;

  // Both capture points (IDLE commit, SLEEP wake-by-irq) latch irq_cause in the
  // same cycle, so the target can be formed from the live cause and registered.
  assign w_mtvec_base = {bus.csr_mtvec[XLEN-1:2], 2'b00};

`ifdef IRQ_VECTORED_EN
  assign w_trap_target = (bus.csr_mtvec[1:0] == 2'b01 && bus.irq_cause[XLEN-1])
                       ? w_mtvec_base + XLEN'({bus.irq_cause[3:0], 2'b00})
                       : w_mtvec_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^bus.csr_mtvec[1:0];
  assign w_trap_target = w_mtvec_base;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt    = r_state;
    w_ret_pc_nxt   = r_ret_pc;
    w_cause_nxt    = r_cause_q;
    w_flush_pc_nxt = r_flush_pc;
    w_kill         = 1'b0;
    w_trap_done    = 1'b0;
    w_ret_done     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmt_vld && bus.irq_req) begin
          w_kill         = 1'b1;
          w_ret_pc_nxt   = bus.cmt_pc;
          w_cause_nxt    = bus.irq_cause;
          w_flush_pc_nxt = w_trap_target;
          w_state_nxt    = ST_TRAP;
        end else if (bus.cmt_vld && bus.cmt_is_mret) begin
          w_flush_pc_nxt = bus.csr_mepc;
          w_state_nxt    = ST_RET;
        end else if (bus.cmt_vld && bus.cmt_is_wfi && !bus.dbg_mode) begin
          w_ret_pc_nxt   = bus.cmt_pc + XLEN'(4);
          w_state_nxt    = ST_SLEEP;
        end
      end
      ST_TRAP: begin
        if (bus.flush_ack) begin
          w_trap_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RET: begin
        if (bus.flush_ack) begin
          w_ret_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SLEEP: begin
        // Commits are ignored here; ret_pc already holds the instruction after the WFI.
        if (bus.irq_req) begin
          w_cause_nxt    = bus.irq_cause;
          w_flush_pc_nxt = w_trap_target;
          w_state_nxt    = ST_TRAP;
        end else if (bus.wfi_irq_req) begin
          w_flush_pc_nxt = r_ret_pc;
          w_state_nxt    = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (bus.flush_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ret_pc    <= '0;
      r_cause_q   <= '0;
      r_flush_pc  <= '0;
      r_flush_req <= 1'b0;
      r_wfi_flag  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_pc    <= w_ret_pc_nxt;
      r_cause_q   <= w_cause_nxt;
      r_flush_pc  <= w_flush_pc_nxt;
      r_flush_req <= (w_state_nxt == ST_TRAP) || (w_state_nxt == ST_RET) ||
                     (w_state_nxt == ST_WAKE);
      r_wfi_flag  <= (w_state_nxt == ST_SLEEP);
    end
  end

  assign bus.cmt_kill     = w_kill;
  assign bus.flush_req    = r_flush_req;
  assign bus.flush_pc     = r_flush_pc;
  assign bus.mepc_we      = w_trap_done;
  assign bus.mcause_we    = w_trap_done;
  assign bus.mepc_wdata   = r_ret_pc;
  assign bus.mcause_wdata = r_cause_q;
  assign bus.trap_enter   = w_trap_done;
  assign bus.trap_exit    = w_ret_done;
  assign bus.wfi_flag_r   = r_wfi_flag;
  assign bus.halt_req     = r_wfi_flag;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: directed scenarios plus randomized
// commit/sleep sequences checked against a transaction-level reference model.
module tb_irq_trap_ctrl;
  localparam int XLEN = 32;

  localparam logic [7:0] S_KILL   = 8'h80;
  localparam logic [7:0] S_FREQ   = 8'h40;
  localparam logic [7:0] S_MEPC   = 8'h20;
  localparam logic [7:0] S_MCAUSE = 8'h10;
  localparam logic [7:0] S_ENTER  = 8'h08;
  localparam logic [7:0] S_EXIT   = 8'h04;
  localparam logic [7:0] S_WFI    = 8'h02;
  localparam logic [7:0] S_HALT   = 8'h01;

  localparam int K_TRAP = 0;
  localparam int K_RET  = 1;
  localparam int K_WAKE = 2;

  typedef enum int {EV_NONE, EV_TRAP, EV_RET, EV_SLEEP} ev_e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  irq_trap_ctrl_if #(.XLEN(XLEN)) bus ();

  irq_trap_ctrl #(.XLEN(XLEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- reference model ----------------
  function automatic ev_e classify(input logic vld, input logic irq, input logic mret,
                                   input logic wfi, input logic dbg);
    if (!vld)           return EV_NONE;
    if (irq)            return EV_TRAP;
    if (mret)           return EV_RET;
    if (wfi && !dbg)    return EV_SLEEP;
    return EV_NONE;
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = (mtvec / 4) * 4;
`ifdef IRQ_VECTORED_EN
    if ((mtvec % 4) == 1 && cause >= 32'h8000_0000) return base + 4 * (cause % 16);
`endif
    if (cause === 32'hx) return base;
    return base;
  endfunction

  function automatic logic [7:0] stat();
    return {bus.cmt_kill, bus.flush_req, bus.mepc_we, bus.mcause_we,
            bus.trap_enter, bus.trap_exit, bus.wfi_flag_r, bus.halt_req};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dbg_mode    = 1'b0;
    bus.irq_req     = 1'b0;
    bus.wfi_irq_req = 1'b0;
    bus.cmt_vld     = 1'b0;
    bus.cmt_is_wfi  = 1'b0;
    bus.cmt_is_mret = 1'b0;
    bus.flush_ack   = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic irq, input logic mret,
                        input logic wfi, input logic dbg, input logic [31:0] cause);
    bus.cmt_vld     = 1'b1;
    bus.cmt_pc      = pc;
    bus.irq_req     = irq;
    bus.cmt_is_mret = mret;
    bus.cmt_is_wfi  = wfi;
    bus.dbg_mode    = dbg;
    bus.irq_cause   = cause;
    #1;
  endtask

  // Drives one flush handshake with 'delay' stalled cycles; unrelated inputs are
  // scrambled while stalled to show they cannot disturb an in-flight sequence.
  task automatic do_flush(input string name, input logic [31:0] exp_pc, input int kind,
                          input logic [31:0] exp_mepc, input logic [31:0] exp_cause,
                          input int delay);
    logic [7:0] exp_s;
    for (int i = 0; i < delay; i++) begin
      bus.irq_cause   = $urandom;
      bus.csr_mtvec   = $urandom;
      bus.csr_mepc    = $urandom;
      bus.cmt_pc      = $urandom;
      bus.cmt_vld     = 1'($urandom);
      bus.irq_req     = 1'($urandom);
      bus.wfi_irq_req = 1'($urandom);
      bus.cmt_is_mret = 1'($urandom);
      bus.cmt_is_wfi  = 1'($urandom);
      #1;
      checks++;
      if (stat() !== S_FREQ || bus.flush_pc !== exp_pc) begin
        errors++;
        $display("FAIL %s_stall%0d: stat=%h pc=%h, expected stat=%h pc=%h",
                 name, i, stat(), bus.flush_pc, S_FREQ, exp_pc);
      end
      tick();
    end
    bus.flush_ack = 1'b1;
    #1;
    exp_s = S_FREQ | ((kind == K_TRAP) ? (S_MEPC | S_MCAUSE | S_ENTER) :
                      (kind == K_RET)  ? S_EXIT : 8'h00);
    checks++;
    if (stat() !== exp_s || bus.flush_pc !== exp_pc) begin
      errors++;
      $display("FAIL %s_ack: stat=%h pc=%h, expected stat=%h pc=%h",
               name, stat(), bus.flush_pc, exp_s, exp_pc);
    end
    if (kind == K_TRAP) begin
      checks++;
      if (bus.mepc_wdata !== exp_mepc || bus.mcause_wdata !== exp_cause) begin
        errors++;
        $display("FAIL %s_csr: mepc=%h mcause=%h, expected mepc=%h mcause=%h",
                 name, bus.mepc_wdata, bus.mcause_wdata, exp_mepc, exp_cause);
      end
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (stat() !== 8'h00) begin
      errors++;
      $display("FAIL %s_done: stat=%h, expected 00", name, stat());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    bus.irq_cause = '0;
    bus.cmt_pc    = '0;
    bus.csr_mtvec = '0;
    bus.csr_mepc  = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (stat() !== 8'h00 || bus.flush_pc !== 32'h0 ||
        bus.mepc_wdata !== 32'h0 || bus.mcause_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset: stat=%h pc=%h mepc=%h mcause=%h, expected all 0",
               stat(), bus.flush_pc, bus.mepc_wdata, bus.mcause_wdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_irq_commit();
    bus.csr_mtvec = 32'h200;
    commit(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_000B);
    checks++;
    if (stat() !== S_KILL) begin
      errors++;
      $display("FAIL irq_kill: stat=%h, expected %h", stat(), S_KILL);
    end
    tick();
    idle_inputs();
    do_flush("irq", 32'h200, K_TRAP, 32'h100, 32'h8000_000B, 0);
  endtask

  task automatic test_mret();
    bus.csr_mepc = 32'h340;
    commit(32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (stat() !== 8'h00) begin
      errors++;
      $display("FAIL mret_commit: stat=%h, expected 00", stat());
    end
    tick();
    idle_inputs();
    do_flush("mret", 32'h340, K_RET, 32'h0, 32'h0, 0);
  endtask

  task automatic test_wfi_wake();
    commit(32'h80, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.cmt_vld     = 1'($urandom);
      bus.cmt_is_mret = 1'($urandom);
      bus.cmt_is_wfi  = 1'($urandom);
      #1;
      checks++;
      if (stat() !== (S_WFI | S_HALT)) begin
        errors++;
        $display("FAIL wfi_sleep%0d: stat=%h, expected %h", i, stat(), S_WFI | S_HALT);
      end
      tick();
    end
    idle_inputs();
    bus.wfi_irq_req = 1'b1;
    #1;
    checks++;
    if (stat() !== (S_WFI | S_HALT)) begin
      errors++;
      $display("FAIL wfi_wake_req: stat=%h, expected %h", stat(), S_WFI | S_HALT);
    end
    tick();
    idle_inputs();
    do_flush("wfi_wake", 32'h84, K_WAKE, 32'h0, 32'h0, 1);
  endtask

  task automatic test_wfi_trap();
    bus.csr_mtvec = 32'h200;
    commit(32'h80, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    idle_inputs();
    bus.irq_req   = 1'b1;
    bus.irq_cause = 32'h8000_0007;
    #1;
    checks++;
    if (stat() !== (S_WFI | S_HALT)) begin
      errors++;
      $display("FAIL wfi_trap_req: stat=%h, expected %h", stat(), S_WFI | S_HALT);
    end
    tick();
    idle_inputs();
    do_flush("wfi_trap", 32'h200, K_TRAP, 32'h84, 32'h8000_0007, 1);
  endtask

  task automatic test_backpressure();
    bus.csr_mtvec = 32'h300;
    commit(32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_000B);
    tick();
    idle_inputs();
    do_flush("backpressure", 32'h300, K_TRAP, 32'h1000, 32'h8000_000B, 5);
  endtask

  task automatic test_vectored();
    logic [31:0] exp_pc;
`ifdef IRQ_VECTORED_EN
    exp_pc = 32'h21C;
`else
    exp_pc = 32'h200;
`endif
    bus.csr_mtvec = 32'h201;
    commit(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0007);
    tick();
    idle_inputs();
    do_flush("vectored", exp_pc, K_TRAP, 32'h40, 32'h8000_0007, 0);
    // Exception-style cause (MSB clear) always uses the direct base.
    bus.csr_mtvec = 32'h201;
    commit(32'h48, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0007);
    tick();
    idle_inputs();
    do_flush("vectored_nonirq", 32'h200, K_TRAP, 32'h48, 32'h0000_0007, 0);
  endtask

  task automatic test_dbg_wfi();
    commit(32'h90, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    tick();
    idle_inputs();
    #1;
    checks++;
    if (stat() !== 8'h00) begin
      errors++;
      $display("FAIL dbg_wfi: stat=%h, expected 00", stat());
    end
  endtask

  task automatic test_priority();
    bus.csr_mtvec = 32'h600;
    commit(32'h44, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0003);
    checks++;
    if (stat() !== S_KILL) begin
      errors++;
      $display("FAIL prio_kill: stat=%h, expected %h", stat(), S_KILL);
    end
    tick();
    idle_inputs();
    do_flush("prio_irq", 32'h600, K_TRAP, 32'h44, 32'h8000_0003, 0);
    bus.csr_mepc = 32'h700;
    commit(32'h50, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    idle_inputs();
    do_flush("prio_mret", 32'h700, K_RET, 32'h0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    bus.csr_mtvec = 32'h800;
    commit(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0001);
    tick();
    idle_inputs();
    do_flush("b2b_trap", 32'h800, K_TRAP, 32'h10, 32'h8000_0001, 0);
    // Captured in the very cycle after the ack.
    bus.csr_mepc = 32'h14;
    commit(32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    do_flush("b2b_mret", 32'h14, K_RET, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset_abort();
    bus.csr_mtvec = 32'h900;
    commit(32'h30, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0005);
    tick();
    idle_inputs();
    tick();
    bus.flush_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stat() !== 8'h00) begin
      errors++;
      $display("FAIL reset_abort: stat=%h, expected 00", stat());
    end
    tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();
    checks++;
    if (stat() !== 8'h00 || bus.flush_pc !== 32'h0 || bus.mepc_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort_after: stat=%h pc=%h mepc=%h, expected all 0",
               stat(), bus.flush_pc, bus.mepc_wdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, cause, mtvec, mepc, tgt;
    logic        vld, irq, mret, wfi, dbg;
    ev_e         ev;
    for (int n = 0; n < 150; n++) begin
      mtvec = $urandom;
      mepc  = $urandom;
      pc    = $urandom & 32'hFFFF_FFFC;
      if (n % 10 == 0) pc = 32'hFFFF_FFFC;
      cause = $urandom;
      vld   = ($urandom_range(0, 3) != 0);
      irq   = ($urandom_range(0, 2) == 0);
      mret  = 1'($urandom);
      wfi   = 1'($urandom);
      dbg   = ($urandom_range(0, 3) == 0);
      bus.csr_mtvec = mtvec;
      bus.csr_mepc  = mepc;
      commit(pc, irq, mret, wfi, dbg, cause);
      bus.cmt_vld = vld;
      #1;
      ev = classify(vld, irq, mret, wfi, dbg);
      tgt = exp_target(mtvec, cause);
      checks++;
      if (stat() !== ((ev == EV_TRAP) ? S_KILL : 8'h00)) begin
        errors++;
        $display("FAIL rnd%0d_commit: stat=%h, expected kill=%0d", n, stat(), ev == EV_TRAP);
      end
      tick();
      idle_inputs();
      case (ev)
        EV_TRAP: do_flush("rnd_trap", tgt, K_TRAP, pc, cause, $urandom_range(0, 3));
        EV_RET:  do_flush("rnd_ret", mepc, K_RET, 32'h0, 32'h0, $urandom_range(0, 3));
        EV_SLEEP: begin
          for (int i = 0; i < $urandom_range(0, 3); i++) begin
            bus.cmt_vld     = 1'($urandom);
            bus.cmt_is_mret = 1'($urandom);
            bus.cmt_is_wfi  = 1'($urandom);
            bus.cmt_pc      = $urandom;
            #1;
            checks++;
            if (stat() !== (S_WFI | S_HALT)) begin
              errors++;
              $display("FAIL rnd%0d_sleep: stat=%h, expected %h", n, stat(), S_WFI | S_HALT);
            end
            tick();
          end
          idle_inputs();
          if (1'($urandom)) begin
            cause = $urandom;
            mtvec = $urandom;
            bus.csr_mtvec   = mtvec;
            bus.irq_cause   = cause;
            bus.irq_req     = 1'b1;
            bus.wfi_irq_req = 1'($urandom);
            tick();
            idle_inputs();
            do_flush("rnd_wfi_trap", exp_target(mtvec, cause), K_TRAP, pc + 32'd4, cause,
                     $urandom_range(0, 2));
          end else begin
            bus.wfi_irq_req = 1'b1;
            tick();
            idle_inputs();
            do_flush("rnd_wake", pc + 32'd4, K_WAKE, 32'h0, 32'h0, $urandom_range(0, 2));
          end
        end
        default: begin
          #1;
          checks++;
          if (stat() !== 8'h00) begin
            errors++;
            $display("FAIL rnd%0d_none: stat=%h, expected 00", n, stat());
          end
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_irq_commit();
    test_mret();
    test_wfi_wake();
    test_wfi_trap();
    test_backpressure();
    test_vectored();
    test_dbg_wfi();
    test_priority();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
